switch_debounce_bank: RTL

Parametrised multi-channel successor to the single-switch debouncer for the cube state-input front end. It takes `N_CH` raw, asynchronous switch/button inputs and synchronises each into `clk`. Each channel is debounced with an independent stability counter and produces a clean level, one-cycle rise and fall pulses, and a one-shot long-press (hold) pulse. Downstream face/colour-select logic consumes the pulses directly and needs no edge detection of its own.

---
 rtl/input_pkg.sv | 9 +
 rtl/switch_debounce_bank_channel.sv | 115 +++++++++++
 rtl/switch_debounce_bank.sv | 66 ++++++
 3 files changed

// File: rtl/input_pkg.sv
// Shared defaults for the cube state-input front end. The numbers assume a
// 50 MHz system clock: about 1.3 ms of debounce and a 1 s long-press.
package input_pkg;

   localparam int SYNC_STAGES_DEFAULT = 2;
   localparam int DB_CYCLES_DEFAULT   = 65536;
   localparam int HOLD_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/switch_debounce_bank_channel.sv
// One debounced switch channel. It has a synchroniser chain, a stability
// counter that must see DB_CYCLES differing samples in a row before it accepts
// a new level, and a long-press counter that fires 'hold' once per press.
// 'change_next' is the un-registered rise|fall. The bank combines these so that
// its registered any_change lines up with rise/fall.
module debounce_channel
   import input_pkg::*;
#(
   parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int   DB_CYCLES   = DB_CYCLES_DEFAULT,
   parameter int   HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
   parameter logic INIT_LEVEL  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sw_out,
   output logic rise,
   output logic fall,
   output logic hold,
   output logic change_next
);

   localparam int DCNT_W = $clog2(DB_CYCLES);
   localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [DCNT_W-1:0] DB_LAST   = DCNT_W'(DB_CYCLES - 1);
   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [DCNT_W-1:0]      dcnt;
   logic [DCNT_W-1:0]      dcnt_next;
   logic                   sw_out_next;
   logic                   rise_next;
   logic                   fall_next;
   logic [HCNT_W-1:0]      hcnt;
   logic [HCNT_W-1:0]      hcnt_next;
   logic                   fired;
   logic                   fired_next;
   logic                   hold_next;

   assign s           = sync[SYNC_STAGES-1];
   assign change_next = rise_next | fall_next;

   // Synchroniser chain: shift the raw asynchronous level in toward 's'.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sw_in};
      end
   end

   // Stability check: any agreeing sample restarts the run. The DB_CYCLES-th
   // disagreeing sample in a row flips the level and raises the edge pulse.
   always_comb begin
      dcnt_next   = dcnt;
      sw_out_next = sw_out;
      rise_next   = 1'b0;
      fall_next   = 1'b0;
      if (s == sw_out) begin
         dcnt_next = '0;
      end else if (dcnt == DB_LAST) begin
         dcnt_next   = '0;
         sw_out_next = s;
         rise_next   = s;
         fall_next   = ~s;
      end else begin
         dcnt_next = dcnt + 1'b1;
      end
   end

   // Long-press timing: count while high, fire once, and re-arm only after a
   // release. A release that lands on the firing edge suppresses the pulse.
   always_comb begin
      hcnt_next  = hcnt;
      fired_next = fired;
      hold_next  = 1'b0;
      if (!sw_out) begin
         hcnt_next  = '0;
         fired_next = 1'b0;
      end else if (!fired) begin
         if (hcnt == HOLD_LAST) begin
            if (!fall_next) begin
               hold_next  = 1'b1;
               fired_next = 1'b1;
            end
         end else begin
            hcnt_next = hcnt + 1'b1;
         end
      end
   end

   // State and output registers. Every pulse is a single-cycle register value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt   <= '0;
         sw_out <= INIT_LEVEL;
         rise   <= 1'b0;
         fall   <= 1'b0;
         hcnt   <= '0;
         fired  <= 1'b0;
         hold   <= 1'b0;
      end else begin
         dcnt   <= dcnt_next;
         sw_out <= sw_out_next;
         rise   <= rise_next;
         fall   <= fall_next;
         hcnt   <= hcnt_next;
         fired  <= fired_next;
         hold   <= hold_next;
      end
   end

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of N_CH independent debounced switches for the cube state-input front
// end. Downstream logic uses rise/fall/hold directly. any_change tells it that
// at least one channel produced an edge pulse in this cycle.
module switch_debounce_bank
   import input_pkg::*;
#(
   parameter int   N_CH        = 8,
   parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int   DB_CYCLES   = DB_CYCLES_DEFAULT,
   parameter int   HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
   parameter logic INIT_LEVEL  = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] sw_in,
   output logic [N_CH-1:0] sw_out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] hold,
   output logic            any_change
);

   logic [N_CH-1:0] change_next;

   // Reject parameter sets that would break the counters.
   if (N_CH < 1) begin : g_bad_nch
      $error("switch_debounce_bank: N_CH must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("switch_debounce_bank: SYNC_STAGES must be >= 2");
   end
   if (DB_CYCLES < 2) begin : g_bad_db
      $error("switch_debounce_bank: DB_CYCLES must be >= 2");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("switch_debounce_bank: HOLD_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES),
         .INIT_LEVEL  (INIT_LEVEL)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .sw_in       (sw_in[i]),
         .sw_out      (sw_out[i]),
         .rise        (rise[i]),
         .fall        (fall[i]),
         .hold        (hold[i]),
         .change_next (change_next[i])
      );
   end

   // Register the OR of the channels' next-state edge pulses so it coincides with rise/fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_change <= 1'b0;
      end else begin
         any_change <= |change_next;
      end
   end

endmodule
